// File: rtl/data_mem_wait.sv
// Byte-addressable RV32 data memory with a valid/ready request/response handshake
// and a configurable number of wait cycles between acceptance and response.
module data_mem_wait #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept, commit;

  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              op_we;
  logic [2:0]        op_f3;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;

  logic [1:0]        lane;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              out_of_range, misaligned, f3_ok, err;
  logic [3:0]        be;
  logic [31:0]       rd_word, ld_data, wr_data;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait cycles the commit edge is the acceptance edge, so decode the live inputs
  always_comb begin
    op_we    = lat_we;
    op_f3    = lat_f3;
    op_addr  = lat_addr;
    op_wdata = lat_wdata;
    if (state == IDLE) begin
      op_we    = req_we;
      op_f3    = req_funct3;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end
  end

  // Access decode: byte enables, load extraction and fault detection
  always_comb begin
    lane         = op_addr[1:0];
    word_idx     = op_addr[ADDR_W-1:2];
    mem_idx      = op_addr[IDX_W+1:2];
    out_of_range = 64'(word_idx) >= 64'(DEPTH_WORDS);
    rd_word      = mem[mem_idx];
    byte_sel     = 8'(rd_word >> {lane, 3'b000});
    half_sel     = 16'(rd_word >> {lane[1], 4'b0000});
    wr_data      = op_wdata << {lane, 3'b000};
    misaligned   = 1'b0;
    f3_ok        = 1'b1;
    be           = 4'b0000;
    ld_data      = 32'd0;
    case (op_f3)
      3'b000: begin
        be      = 4'b0001 << lane;
        ld_data = {{24{byte_sel[7]}}, byte_sel};
      end
      3'b001: begin
        be         = 4'b0011 << lane;
        misaligned = lane[0];
        ld_data    = {{16{half_sel[15]}}, half_sel};
      end
      3'b010: begin
        be         = 4'b1111;
        misaligned = |lane;
        ld_data    = rd_word;
      end
      3'b100: begin
        f3_ok   = !op_we;
        ld_data = {24'd0, byte_sel};
      end
      3'b101: begin
        f3_ok      = !op_we;
        misaligned = lane[0];
        ld_data    = {16'd0, half_sel};
      end
      default: f3_ok = 1'b0;
    endcase
    err = !f3_ok || misaligned || out_of_range;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_ready <= (state_nx == IDLE);
      rsp_valid <= (state_nx == RESP);
      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_err   <= err;
        rsp_rdata <= (err || op_we) ? 32'd0 : ld_data;
      end
    end
  end

  // Storage array is not reset; a fault or reset suppresses the write
  always_ff @(posedge clk) begin
    if (commit && op_we && !err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[mem_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_wait.sv
// Bench for data_mem_wait: three instances (2, 0 and 3 wait cycles) driven from
// a vector table plus hand sequences for backpressure, streaming and reset.
module tb_data_mem_wait;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    int          dut;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [2:0]  req_funct3 [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        rsp_valid  [3];
  logic        rsp_ready  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  vec_t vecs[$];
  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  data_mem_wait #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_wait #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  data_mem_wait #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int d, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.dut = d; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic drive(input int d, input logic valid, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[d]  = valid;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
  endtask

  task automatic pop_compare(input int d, input string name);
    rsp_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: response with empty scoreboard", name);
      return;
    end
    e = sb_q.pop_front();
    check({name, ".rdata"}, rsp_rdata[d], e.rdata);
    check({name, ".err"}, 32'(rsp_err[d]), 32'(e.err));
  endtask

  // One full transaction with rsp_ready held high; latency counted in cycles from acceptance
  task automatic run_txn(input vec_t v, input string name);
    int   d;
    int   lat;
    bit   got;
    rsp_t e;
    d = v.dut;
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    drive(d, 1'b1, v.we, v.f3, v.addr, v.wdata);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[d]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL %s.accept: req_ready never high", name);
      return;
    end
    @(posedge clk);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb_q.push_back(e);
    #1;
    drive(d, 1'b0, ~v.we, 3'b010, 32'h0000_0004, 32'hFFFF_FFFF);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[d]) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_checks++; n_errors++;
      void'(sb_q.pop_front());
      $display("FAIL %s.rsp: rsp_valid never high", name);
      return;
    end
    check({name, ".latency"}, 32'(lat), 32'(wait_of(d) + 1));
    pop_compare(d, name);
    @(posedge clk);
    #1;
    check({name, ".valid_drop"}, 32'(rsp_valid[d]), 32'd0);
    check({name, ".ready_back"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   got;
    rsp_t e;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      rsp_ready[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    end

    // Instance 0: two wait cycles
    add(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add(0, 1, 3'b000, 32'h13,  32'hFFFFFF5A, 32'h0,        0);
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'h5AADBEEF, 0);
    add(0, 0, 3'b000, 32'h13,  32'h0,        32'h0000005A, 0);
    add(0, 0, 3'b100, 32'h11,  32'h0,        32'h000000BE, 0);
    add(0, 0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 0);
    add(0, 0, 3'b101, 32'h12,  32'h0,        32'h00005AAD, 0);
    add(0, 0, 3'b000, 32'h12,  32'h0,        32'hFFFFFFAD, 0);
    add(0, 0, 3'b010, 32'h11,  32'h0,        32'h0,        1);
    add(0, 1, 3'b001, 32'h13,  32'hFFFF,     32'h0,        1);
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'h5AADBEEF, 0);
    add(0, 0, 3'b010, DEPTH*4, 32'h0,        32'h0,        1);
    add(0, 0, 3'b011, 32'h10,  32'h0,        32'h0,        1);
    add(0, 1, 3'b010, 32'h0,   32'h0,        32'h0,        0);
    add(0, 1, 3'b010, DEPTH*4, 32'h0BADF00D, 32'h0,        1);
    add(0, 0, 3'b010, 32'h80000010, 32'h0,   32'h0,        1);
    add(0, 0, 3'b010, 32'h0,   32'h0,        32'h0,        0);
    add(0, 0, 3'b101, 32'h11,  32'h0,        32'h0,        1);
    add(0, 1, 3'b100, 32'h10,  32'h77,       32'h0,        1);
    add(0, 1, 3'b001, 32'h12,  32'hABCD1234, 32'h0,        0);
    add(0, 0, 3'b010, 32'h10,  32'h0,        32'h1234BEEF, 0);
    add(0, 1, 3'b010, DEPTH*4-4, 32'hA5A5A5A5, 32'h0,      0);
    add(0, 0, 3'b010, DEPTH*4-4, 32'h0,      32'hA5A5A5A5, 0);
    // Instance 1: zero wait cycles
    add(1, 1, 3'b010, 32'h40,  32'h12345678, 32'h0,        0);
    add(1, 0, 3'b010, 32'h40,  32'h0,        32'h12345678, 0);
    add(1, 0, 3'b001, 32'h42,  32'h0,        32'h00001234, 0);
    add(1, 0, 3'b000, 32'h41,  32'h0,        32'h00000056, 0);
    add(1, 1, 3'b010, 32'h41,  32'h0,        32'h0,        1);
    // Instance 2: three wait cycles
    add(2, 1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h0,        0);
    add(2, 0, 3'b010, 32'h20,  32'h0,        32'hCAFEF00D, 0);

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d.req_ready", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset%0d.rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      check($sformatf("reset%0d.rsp_rdata", d), rsp_rdata[d], 32'd0);
      check($sformatf("reset%0d.rsp_err", d), 32'(rsp_err[d]), 32'd0);
      rst[d] = 1'b0;
    end

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure on instance 0: response held for five cycles, competing request ignored
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    check("bp.ready_idle", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    e.rdata = 32'h1234BEEF; e.err = 1'b0;
    sb_q.push_back(e);
    #1 drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin got = 1'b1; break; end
    end
    check("bp.rsp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d.valid", k), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp%0d.rdata", k), rsp_rdata[0], 32'h1234BEEF);
      check($sformatf("bp%0d.err", k), 32'(rsp_err[0]), 32'd0);
      check($sformatf("bp%0d.req_ready", k), 32'(req_ready[0]), 32'd0);
      drive(0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0);
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    rsp_ready[0] = 1'b1;
    pop_compare(0, "bp.release");
    @(posedge clk);
    #1;
    check("bp.valid_drop", 32'(rsp_valid[0]), 32'd0);
    check("bp.ready_back", 32'(req_ready[0]), 32'd1);
    v.dut = 0; v.we = 0; v.f3 = 3'b010; v.addr = 32'h10; v.wdata = 0;
    v.exp_rdata = 32'h1234BEEF; v.exp_err = 0;
    run_txn(v, "bp.after");

    // Instance 1 streaming: request held high, accepted every second cycle
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rsp_ready[1] = 1'b1;
        drive(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
      end
      check($sformatf("b2b%0d.req_ready", k), 32'(req_ready[1]), 32'((k % 2) == 0));
      check($sformatf("b2b%0d.rsp_valid", k), 32'(rsp_valid[1]), 32'((k % 2) == 1));
      if (rsp_valid[1]) pop_compare(1, $sformatf("b2b%0d", k));
      if (req_ready[1] && req_valid[1]) begin
        e.rdata = 32'h12345678; e.err = 1'b0;
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    check("b2b.queue_empty", 32'(sb_q.size()), 32'd0);

    // Instance 2: reset while a store is still waiting
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 3'b010, 32'h20, 32'h11111111);
    @(posedge clk);
    #1 drive(2, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(posedge clk);
    #2 rst[2] = 1'b1;
    #1;
    check("rst_mid.req_ready", 32'(req_ready[2]), 32'd1);
    check("rst_mid.rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check("rst_mid.rsp_rdata", rsp_rdata[2], 32'd0);
    check("rst_mid.rsp_err", 32'(rsp_err[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    v.dut = 2; v.we = 0; v.f3 = 3'b010; v.addr = 32'h20; v.wdata = 0;
    v.exp_rdata = 32'hCAFEF00D; v.exp_err = 0;
    run_txn(v, "rst_mid.after");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
